ram_sp_init: RTL and testbench

Parametrised synchronous single-port RAM with registered read, read-valid strobe, and a hardware fill engine. After reset or a `clr` request, the fill engine overwrites every word with `INIT_VAL`, so memory contents are always defined. It generalises the existing 8x8 RAM to arbitrary width and depth and replaces its scratch-register role in datapath blocks that need a known-clean buffer.

---
 rtl/ram_sp_init_pkg.sv | 21 ++
 rtl/ram_sp_init_array.sv | 47 ++++
 rtl/ram_sp_init.sv | 113 +++++++++++
 tb/tb_ram_sp_init.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sp_init_pkg.sv
// Shared definitions for the initialised single-port RAM: controller state
// encoding and a ceiling-log2 helper for derived widths.
package ram_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_IDLE = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_sp_init_array.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered,
// read-first read port sharing a single address.
module ram_array #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Storage itself is never reset; the fill engine gives it defined contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Samples the pre-write word, so a same-cycle read and write is read-first.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_sp_init.sv
// Single-port RAM with registered read and a fill engine that writes INIT_VAL
// to every word after reset or a clr request.
module ram_sp_init
    import ram_pkg::*;
#(
    parameter int unsigned        DATA_W   = 8,
    parameter int unsigned        ADDR_W   = 3,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] add,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    state_e            state_d, state_q;
    logic [PTR_W-1:0]  ptr_d, ptr_q;
    logic              busy_d, busy_q;
    logic              err_d, err_q;
    logic              rd_valid_d, rd_valid_q;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        err_d      = 1'b0;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = add;
        mem_wdata  = data_in;

        unique case (state_q)
            S_FILL: begin
                // The pointer wraps to 0 naturally on the final fill write.
                mem_we    = 1'b1;
                mem_addr  = ADDR_W'(ptr_q);
                mem_wdata = INIT_VAL;
                ptr_d     = ptr_q + 1'b1;
                err_d     = wr | rd | clr;
                if (ptr_q == PTR_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_IDLE: begin
                mem_we     = wr;
                mem_re     = rd;
                rd_valid_d = rd;
                if (clr) begin
                    state_d = S_FILL;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_FILL;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FILL;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (data_out)
    );

    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ram_sp_init.sv
// Self-checking bench: an 8x8 instance with INIT_VAL 8'hA5 against a
// behavioural model, plus a 64x32 instance for the parametrised checks.
module tb_ram_sp_init;

    localparam logic [7:0] INIT_A = 8'hA5;
    localparam int         DEPTH_A = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0;
    logic [2:0] add = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       rd_valid, busy, err;

    logic        rst_b_n = 1'b0, wr_b = 1'b0, rd_b = 1'b0, clr_b = 1'b0;
    logic [5:0]  add_b = '0;
    logic [31:0] din_b = '0;
    logic [31:0] dout_b;
    logic        rv_b, busy_b, err_b;

    int checks = 0;
    int fails  = 0;

    ram_sp_init #(
        .DATA_W   (8),
        .ADDR_W   (3),
        .INIT_VAL (INIT_A)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wr),
        .rd       (rd),
        .add      (add),
        .data_in  (data_in),
        .clr      (clr),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .busy     (busy),
        .err      (err)
    );

    ram_sp_init #(
        .DATA_W (32),
        .ADDR_W (6)
    ) dut_wide (
        .clk      (clk),
        .rst_n    (rst_b_n),
        .wr       (wr_b),
        .rd       (rd_b),
        .add      (add_b),
        .data_in  (din_b),
        .clr      (clr_b),
        .data_out (dout_b),
        .rd_valid (rv_b),
        .busy     (busy_b),
        .err      (err_b)
    );

    // Reference model: contents become INIT_A as soon as a fill starts, since no
    // user access can observe the array until the fill countdown expires.
    logic [7:0] m [DEPTH_A];
    int         fill_left = 0;
    logic [7:0] dout_e = '0;
    logic       rv_e = 1'b0, err_e = 1'b0;

    function automatic logic [10:0] exp_vec();
        return {(fill_left > 0), err_e, rv_e, dout_e};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {busy, err, rd_valid, data_out};
    endfunction

    task automatic step(input logic r_n, input logic w, input logic r, input logic c,
                        input logic [2:0] a, input logic [7:0] d);
        rst_n = r_n; wr = w; rd = r; clr = c; add = a; data_in = d;
        @(posedge clk);
        #1;
        if (!r_n) begin
            fill_left = DEPTH_A; dout_e = '0; rv_e = 1'b0; err_e = 1'b0;
            for (int i = 0; i < DEPTH_A; i++) m[i] = INIT_A;
        end else if (fill_left > 0) begin
            err_e = w | r | c; rv_e = 1'b0; fill_left--;
        end else begin
            err_e = 1'b0; rv_e = r;
            if (r) dout_e = m[a];
            if (w) m[a] = d;
            if (c) begin
                fill_left = DEPTH_A;
                for (int i = 0; i < DEPTH_A; i++) m[i] = INIT_A;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 8'h3C);
        checks++;
        if ({busy, err, rd_valid, data_out} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL reset_state: got busy/err/rv/dout=%b/%b/%b/%h required 1/0/0/00",
                     busy, err, rd_valid, data_out);
        end
    endtask

    task automatic test_reset_fill();
        int cnt;
        cnt = busy ? 1 : 0;
        for (int g = 0; g < 20 && busy === 1'b1; g++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
            if (busy === 1'b1) cnt++;
        end
        checks++;
        if (cnt !== 8) begin
            fails++;
            $display("FAIL reset_fill_busy_cycles: got %0d required 8", cnt);
        end
        for (int k = 0; k < DEPTH_A; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 3'(k), 8'h00);
            checks++;
            if (dut_vec() !== exp_vec() || data_out !== INIT_A) begin
                fails++;
                $display("FAIL reset_fill_read[%0d]: got %h required %h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_sweep();
        for (int k = 0; k < DEPTH_A; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 3'(k), 8'(k + 1));
        for (int k = 0; k < DEPTH_A; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 3'(k), 8'h00);
            checks++;
            if (dut_vec() !== exp_vec() || data_out !== 8'(k + 1) || rd_valid !== 1'b1) begin
                fails++;
                $display("FAIL sweep_read[%0d]: got %h required %h", k, dut_vec(), exp_vec());
            end
        end
        repeat (2) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00);
            checks++;
            if (data_out !== 8'd8 || rd_valid !== 1'b0) begin
                fails++;
                $display("FAIL sweep_hold: got dout=%h rv=%b required 08 0", data_out, rd_valid);
            end
        end
    endtask

    task automatic test_same_cycle();
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 8'h04);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 8'h55);
        checks++;
        if (data_out !== 8'h04 || rd_valid !== 1'b1) begin
            fails++;
            $display("FAIL same_cycle_old: got dout=%h rv=%b required 04 1", data_out, rd_valid);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 8'h00);
        checks++;
        if (data_out !== 8'h55 || dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL same_cycle_new: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_clear();
        int cnt;
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 8'h77);
        cnt = busy ? 1 : 0;
        for (int g = 0; g < 20 && busy === 1'b1; g++) begin
            step(1'b1, 1'b0, (g == 2), 1'b0, 3'd6, 8'h00);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL clear_fill[%0d]: got %h required %h", g, dut_vec(), exp_vec());
            end
            if (busy === 1'b1) cnt++;
        end
        checks++;
        if (cnt !== 8) begin
            fails++;
            $display("FAIL clear_busy_cycles: got %0d required 8", cnt);
        end
        for (int k = 0; k < DEPTH_A; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 3'(k), 8'h00);
            checks++;
            if (data_out !== INIT_A || rd_valid !== 1'b1) begin
                fails++;
                $display("FAIL clear_read[%0d]: got dout=%h rv=%b required %h 1",
                         k, data_out, rd_valid, INIT_A);
            end
        end
    endtask

    task automatic test_mid_fill_reset();
        int cnt;
        for (int k = 0; k < DEPTH_A; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 3'(k), 8'(8'h10 + k));
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
        cnt = busy ? 1 : 0;
        for (int g = 0; g < 20 && busy === 1'b1; g++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
            if (busy === 1'b1) cnt++;
        end
        checks++;
        if (cnt !== 8) begin
            fails++;
            $display("FAIL mid_fill_reset_busy_cycles: got %0d required 8", cnt);
        end
        for (int k = 0; k < DEPTH_A; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 3'(k), 8'h00);
            checks++;
            if (data_out !== INIT_A || dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL mid_fill_reset_read[%0d]: got %h required %h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0), 3'($urandom), 8'($urandom));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random[%0d]: got %h required %h", n, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_param();
        int cnt;
        rst_b_n = 1'b0; wr_b = 1'b0; rd_b = 1'b0; clr_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_b_n = 1'b1;
        cnt = busy_b ? 1 : 0;
        for (int g = 0; g < 100 && busy_b === 1'b1; g++) begin
            @(posedge clk);
            #1;
            if (busy_b === 1'b1) cnt++;
        end
        checks++;
        if (cnt !== 64) begin
            fails++;
            $display("FAIL param_busy_cycles: got %0d required 64", cnt);
        end
        wr_b = 1'b1; add_b = 6'd63; din_b = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        wr_b = 1'b0; rd_b = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dout_b !== 32'hDEADBEEF || rv_b !== 1'b1) begin
            fails++;
            $display("FAIL param_read63: got %h rv=%b required deadbeef 1", dout_b, rv_b);
        end
        add_b = 6'd0;
        @(posedge clk);
        #1;
        rd_b = 1'b0;
        checks++;
        if (dout_b !== 32'h0 || err_b !== 1'b0) begin
            fails++;
            $display("FAIL param_read0: got %h err=%b required 00000000 0", dout_b, err_b);
        end
    endtask

    initial begin
        test_reset();
        test_reset_fill();
        test_sweep();
        test_same_cycle();
        test_clear();
        test_mid_fill_reset();
        test_random();
        test_param();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
